// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Instruction fetch address generator and {pc, instr} FIFO
//                feeding the decode stage, with single-cycle redirect/flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [31:0]                imem_a,
    input  logic [31:0]                imem_rd,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL_COUNT = CW'(DEPTH);

    logic [31:0]   r_pc;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_valid;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && out_ready && !redirect;
    // A full queue can still accept a word when the head leaves on the same edge.
    assign w_push  = !redirect && ((r_count < c_FULL_COUNT) || w_pop);

    assign imem_a    = r_pc;
    assign out_valid = w_valid;
    assign out_pc    = w_valid ? r_mem_pc[r_rptr]    : 32'h0;
    assign out_instr = w_valid ? r_mem_instr[r_rptr] : 32'h0;
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 32'd4;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is left unreset; the output mux hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]    <= r_pc;
            r_mem_instr[r_wptr] <= imem_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Self-checking bench for instr_fetch_queue (directed table,
//                async reset sequence, randomized run against a queue model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;

    logic [63:0] mq[$];
    logic [31:0] mpc;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0:   mem_f = 32'h0050_0093;
            32'h4:   mem_f = 32'h0010_0113;
            32'h8:   mem_f = 32'h0020_81B3;
            32'hC:   mem_f = 32'h0000_0013;
            default: mem_f = a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    assign imem_rd = mem_f(imem_a);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = 32'h0;
    endtask

    // Drive inputs, take one rising edge, advance the model, settle.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic pop, push;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(posedge clk);
        if (rd) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            pop  = (mq.size() != 0) && rdy;
            push = (mq.size() < DEPTH) || pop;
            if (pop)  void'(mq.pop_front());
            if (push) begin
                mq.push_back({mpc, mem_f(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic        ev;
        logic [31:0] epc, ein;
        ev  = (mq.size() != 0);
        epc = ev ? mq[0][63:32] : 32'h0;
        ein = ev ? mq[0][31:0]  : 32'h0;
        chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, ev});
        chk({tag, ".pc"},    out_pc, epc);
        chk({tag, ".instr"}, out_instr, ein);
        chk({tag, ".count"}, {29'h0, count}, 32'(mq.size()));
        chk({tag, ".imem_a"}, imem_a, mpc);
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [2:0]  ecnt;
        logic [31:0] ea;
    } vec_t;

    vec_t vt[16];

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // Backpressure from reset, redirect while full, wrap, redirect with 3 entries.
        vt[0]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0050_0093, 3'd1, 32'h4};
        vt[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0050_0093, 3'd2, 32'h8};
        vt[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0050_0093, 3'd3, 32'hC};
        vt[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0050_0093, 3'd4, 32'h10};
        vt[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0050_0093, 3'd4, 32'h10};
        vt[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h0010_0113, 3'd4, 32'h14};
        vt[6]  = '{1'b1, 32'h9,         1'b1, 1'b0, 32'h0,         32'h0,         3'd0, 32'h8};
        vt[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h0020_81B3, 3'd1, 32'hC};
        vt[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h0020_81B3, 3'd2, 32'h10};
        vt[9]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'h0,         3'd0, 32'hFFFF_FFFC};
        vt[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 32'h2152_4113, 3'd1, 32'h0};
        vt[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h0050_0093, 3'd1, 32'h4};
        vt[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0050_0093, 3'd2, 32'h8};
        vt[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0050_0093, 3'd3, 32'hC};
        vt[14] = '{1'b1, 32'h9,         1'b0, 1'b0, 32'h0,         32'h0,         3'd0, 32'h8};
        vt[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h0020_81B3, 3'd1, 32'hC};

        // Reset state
        do_reset();
        chk("rst.valid",  {31'h0, out_valid}, 32'h0);
        chk("rst.count",  {29'h0, count}, 32'h0);
        chk("rst.imem_a", imem_a, 32'h0);
        chk("rst.pc",     out_pc, 32'h0);
        chk("rst.instr",  out_instr, 32'h0);

        // Drain with out_ready=1 from reset
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk($sformatf("drain%0d.valid", i), {31'h0, out_valid}, 32'h1);
            chk($sformatf("drain%0d.pc", i), out_pc, 32'(i * 4));
            chk($sformatf("drain%0d.instr", i), out_instr, mem_f(32'(i * 4)));
            chk($sformatf("drain%0d.count", i), {29'h0, count}, 32'h1);
            chk($sformatf("drain%0d.imem_a", i), imem_a, 32'(i * 4 + 4));
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(vt[i].rd, vt[i].rpc, vt[i].rdy);
            chk($sformatf("vec%0d.valid", i), {31'h0, out_valid}, {31'h0, vt[i].ev});
            chk($sformatf("vec%0d.pc", i), out_pc, vt[i].epc);
            chk($sformatf("vec%0d.instr", i), out_instr, vt[i].ein);
            chk($sformatf("vec%0d.count", i), {29'h0, count}, {29'h0, vt[i].ecnt});
            chk($sformatf("vec%0d.imem_a", i), imem_a, vt[i].ea);
        end

        // Asynchronous reset between edges with three entries queued
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        chk("async.pre_count", {29'h0, count}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.valid",  {31'h0, out_valid}, 32'h0);
        chk("async.imem_a", imem_a, 32'h0);
        chk("async.count",  {29'h0, count}, 32'h0);
        chk("async.pc",     out_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 32'h0, 1'b0);
        check_model("async.resume");

        // Randomized run against the queue model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        rd, rdy;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            rdy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(rd, rpc, rdy);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
